// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
//   muldiv_op_t    : RV32M funct3 encoding of the eight M-extension ops
//   muldiv_state_t : sequencer states
//   alu_op_t       : control codes of the execute-stage alu
//   MULDIV_ITER    : radix-2 iterations per operation
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_t;

  localparam int unsigned MULDIV_ITER = 32;
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITER);

  // Two's-complement negate v when s is set.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic s);
    return s ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_alu.sv
// Execute-stage alu, one private instance inside the multiply/divide sequencer.
//   a, b        : 32-bit operands
//   alu_control : operation select (alu_op_t)
//   y           : 32-bit result
module muldiv_sequencer_alu
  import muldiv_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_control,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    case (alu_control)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit (shift-add multiply, restoring divide).
//   clk, reset      : clock, synchronous active-high reset
//   flush           : abort any operation and drop a held result
//   start_valid/ready, op, a, b : request handshake and operands
//   result_valid/ready, result  : result handshake, result held while waiting
//   busy            : iterating or fixing up the sign
// FASTPATH=1 completes div-by-zero and signed overflow on the accepting edge.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter bit FASTPATH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        busy
);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic [31:0]   hi_q, hi_d;     // product high word / partial remainder
  logic [31:0]   lo_q, lo_d;     // multiplier then product low word / quotient
  logic [31:0]   opnd_q, opnd_d; // multiplicand / divisor magnitude
  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic          negw_q, negw_d; // negate product or quotient
  logic          negr_q, negr_d; // negate remainder
  logic [31:0]   result_q, result_d;

  muldiv_op_t  op_in;
  logic        in_div, sa, sb, b_zero, ovf, op_is_div;
  logic [31:0] rem_sh, alu_a, alu_y, mul_sum, fix_word;
  logic        mul_carry, qbit;
  logic [63:0] prod_fix;
  alu_op_t     alu_ctl;

  always_comb begin
    op_in  = muldiv_op_t'(op);
    in_div = op_in inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    sa     = a[31] & (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb     = b[31] & (op_in inside {MD_MULH, MD_DIV, MD_REM});
    b_zero = (b == '0);
    ovf    = (op_in inside {MD_DIV, MD_REM}) && (a == 32'h8000_0000) && (b == '1);
  end

  always_comb begin
    op_is_div = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    rem_sh    = {hi_q[30:0], lo_q[31]};
    alu_a     = op_is_div ? rem_sh : hi_q;
    alu_ctl   = (state_q == ST_CALC && op_is_div) ? ALU_SUB : ALU_ADD;
  end

  muldiv_sequencer_alu u_alu (
    .a           (alu_a),
    .b           (opnd_q),
    .alu_control (alu_ctl),
    .y           (alu_y)
  );

  always_comb begin
    mul_sum   = lo_q[0] ? alu_y : hi_q;
    mul_carry = lo_q[0] & (alu_y < hi_q);
    qbit      = hi_q[31] | (rem_sh >= opnd_q);
    prod_fix  = negw_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    case (op_q)
      MD_MUL:                        fix_word = prod_fix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_word = prod_fix[63:32];
      MD_DIV, MD_DIVU:               fix_word = neg_if(lo_q, negw_q);
      default:                       fix_word = neg_if(hi_q, negr_q);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    negw_d   = negw_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            op_d   = op_in;
            hi_d   = '0;
            lo_d   = neg_if(a, sa);
            opnd_d = neg_if(b, sb);
            cnt_d  = '0;
            // Quotient sign is dropped for b==0 so the iterated all-ones
            // quotient matches the architectural -1 for signed DIV too.
            negw_d = (sa ^ sb) & ~(in_div & b_zero);
            negr_d = sa;
            if (FASTPATH && in_div && (b_zero || ovf)) begin
              state_d = ST_DONE;
              if (b_zero) begin
                result_d = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : a;
              end else begin
                result_d = (op_in == MD_DIV) ? 32'h8000_0000 : '0;
              end
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (op_is_div) begin
            hi_d = qbit ? alu_y : rem_sh;
            lo_d = {lo_q[30:0], qbit};
          end else begin
            hi_d = {mul_carry, mul_sum[31:1]};
            lo_d = {mul_sum[0], lo_q[31:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == MULDIV_CNT_W'(MULDIV_ITER - 1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = fix_word;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (result_ready) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      negw_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      negw_q   <= negw_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign result       = result_q;

endmodule
